// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared types, flag indices and width helpers for the FP multiplier
// Contents:
//   op_class_e         operand classification after decode
//   FLAG_*             bit positions inside the {nv, of, uf, nx} flag vector
//   calc_bias/full/prod  width-derived constants for a given exponent/fraction width
//   canon_qnan         canonical quiet NaN pattern, right-aligned in a wide vector
package fp_mult_pkg;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } op_class_e;

   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // Widest format canon_qnan can describe; callers truncate to their width.
   localparam int QNAN_MAX_W = 128;

   function automatic int calc_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int calc_full_w(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int calc_prod_w(input int man_w);
      return 2 * (man_w + 1);
   endfunction

   // Sign 0, exponent all ones, fraction MSB set, remaining fraction bits 0.
   function automatic logic [QNAN_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
      logic [QNAN_MAX_W-1:0] r;
      r = '0;
      for (int i = man_w; i < man_w + exp_w; i++) begin
         r[i] = 1'b1;
      end
      r[man_w-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even on a normalised mantissa product
// Ports:
//   man    product bits below the hidden one (leading one already removed)
//   frac   rounded MAN_W-bit fraction (wraps to 0 on carry-out)
//   carry  rounding overflowed the fraction; caller bumps the exponent
//   nx     any discarded bit was set
module fp_round_rne #(
   parameter int MAN_W = 23
) (
   input  logic [2*MAN_W:0]  man,
   output logic [MAN_W-1:0]  frac,
   output logic              carry,
   output logic              nx
);

   logic [MAN_W-1:0] trunc;
   logic             guard;
   logic             sticky;
   logic             inc;
   logic [MAN_W:0]   sum;

   always_comb begin
      trunc  = man[2*MAN_W -: MAN_W];
      guard  = man[MAN_W];
      sticky = |man[MAN_W-1:0];
      // Ties go up only when the kept LSB is odd.
      inc    = guard & (sticky | trunc[0]);
      sum    = {1'b0, trunc} + {{MAN_W{1'b0}}, inc};
      frac   = sum[MAN_W-1:0];
      carry  = sum[MAN_W];
      nx     = guard | sticky;
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - four-stage pipelined floating-point multiplier with valid/ready handshake
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake; a, b operands {sign, exp, frac}; in_tag user tag
//   out_valid, out_ready result handshake; result packed product, out_tag, flags {nv, of, uf, nx}
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [TAG_W-1:0]         out_tag,
   output logic [3:0]               flags
);

   localparam int W   = calc_full_w(EXP_W, MAN_W);
   localparam int PW  = calc_prod_w(MAN_W);
   localparam int EW2 = EXP_W + 2;

   localparam logic [W-1:0]          QNAN_VAL = W'(canon_qnan(EXP_W, MAN_W));
   localparam logic signed [EW2-1:0] BIAS_E   = EW2'(calc_bias(EXP_W));
   localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);

   // Global stall: every stage moves together or not at all.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   function automatic op_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == {EXP_W{1'b1}}) begin
         if (f == '0)          return CLS_INF;
         else if (f[MAN_W-1])  return CLS_QNAN;
         else                  return CLS_SNAN;
      end else if (e == '0) begin
         return CLS_ZERO;   // subnormals are treated as zero
      end
      return CLS_NORM;
   endfunction

   // ---------------- S1 decode ----------------
   logic [EXP_W-1:0]       ea, eb;
   logic [MAN_W-1:0]       fa, fb;
   op_class_e              cls_a, cls_b;
   logic                   sign_p;
   logic signed [EW2-1:0]  exp_sum;
   logic                   sp_hit;
   logic [W-1:0]           sp_res;
   logic [3:0]             sp_flg;

   assign ea     = a[W-2 -: EXP_W];
   assign eb     = b[W-2 -: EXP_W];
   assign fa     = a[MAN_W-1:0];
   assign fb     = b[MAN_W-1:0];
   assign sign_p = a[W-1] ^ b[W-1];
   assign cls_a  = classify(ea, fa);
   assign cls_b  = classify(eb, fb);
   // Two extra bits keep the biased sum from wrapping in either direction.
   assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS_E;

   always_comb begin
      sp_hit = 1'b0;
      sp_res = '0;
      sp_flg = '0;
      if (cls_a == CLS_QNAN || cls_a == CLS_SNAN || cls_b == CLS_QNAN || cls_b == CLS_SNAN) begin
         sp_hit          = 1'b1;
         sp_res          = QNAN_VAL;
         sp_flg[FLAG_NV] = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
      end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
         sp_hit          = 1'b1;
         sp_res          = QNAN_VAL;
         sp_flg[FLAG_NV] = 1'b1;
      end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
         sp_hit = 1'b1;
         sp_res = {sign_p, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
         sp_hit = 1'b1;
         sp_res = {sign_p, {(EXP_W + MAN_W){1'b0}}};
      end
   end

   // ---------------- stage registers ----------------
   logic                   v1, v2, v3;
   logic [TAG_W-1:0]       tag1, tag2, tag3;
   logic                   sign1, sign2, sign3;
   logic signed [EW2-1:0]  exp1, exp2, exp3;
   logic [MAN_W-1:0]       fa1, fb1;
   logic [PW-1:0]          prod2;
   logic [MAN_W-1:0]       frac3;
   logic                   carry3, nx3;
   logic                   spec1, spec2, spec3;
   logic [W-1:0]           sres1, sres2, sres3;
   logic [3:0]             sflg1, sflg2, sflg3;

   // ---------------- S3 normalise + round ----------------
   logic [PW-2:0]          rnd_in;
   logic [MAN_W-1:0]       rnd_frac;
   logic                   rnd_carry, rnd_nx;

   // Product of two [1,2) mantissas lies in [1,4); align so the hidden one sits at PW-1 and drop it.
   assign rnd_in = prod2[PW-1] ? prod2[PW-2:0] : {prod2[PW-3:0], 1'b0};

   fp_round_rne #(.MAN_W(MAN_W)) u_round (
      .man   (rnd_in),
      .frac  (rnd_frac),
      .carry (rnd_carry),
      .nx    (rnd_nx)
   );

   // ---------------- S4 post-round + pack ----------------
   logic signed [EW2-1:0]  exp_f;
   logic [W-1:0]           res4;
   logic [3:0]             flg4;

   always_comb begin
      exp_f = exp3 + EW2'(carry3);
      res4  = '0;
      flg4  = '0;
      if (spec3) begin
         res4 = sres3;
         flg4 = sflg3;
      end else if (!exp_f[EW2-1] && (exp_f >= EXP_MAX)) begin
         res4          = {sign3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg4[FLAG_OF] = 1'b1;
         flg4[FLAG_NX] = 1'b1;
      end else if (exp_f[EW2-1] || (exp_f == '0)) begin
         res4          = {sign3, {(EXP_W + MAN_W){1'b0}}};
         flg4[FLAG_UF] = 1'b1;
         flg4[FLAG_NX] = 1'b1;
      end else begin
         res4          = {sign3, exp_f[EXP_W-1:0], frac3};
         flg4[FLAG_NX] = nx3;
      end
   end

   // Valids and outputs: reset clears everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
         flags     <= '0;
      end else if (advance) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
         // Outputs only change when a real result lands, so they stay put across bubbles.
         if (v3) begin
            result  <= res4;
            out_tag <= tag3;
            flags   <= flg4;
         end
      end
   end

   // Datapath payload; qualified by the valids above.
   always_ff @(posedge clk) begin
      if (advance) begin
         tag1   <= in_tag;
         sign1  <= sign_p;
         exp1   <= exp_sum;
         fa1    <= fa;
         fb1    <= fb;
         spec1  <= sp_hit;
         sres1  <= sp_res;
         sflg1  <= sp_flg;

         tag2   <= tag1;
         sign2  <= sign1;
         exp2   <= exp1;
         prod2  <= PW'({1'b1, fa1}) * PW'({1'b1, fb1});
         spec2  <= spec1;
         sres2  <= sres1;
         sflg2  <= sflg1;

         tag3   <= tag2;
         sign3  <= sign2;
         exp3   <= exp2 + EW2'(prod2[PW-1]);
         frac3  <= rnd_frac;
         carry3 <= rnd_carry;
         nx3    <= rnd_nx;
         spec3  <= spec2;
         sres3  <= sres2;
         sflg3  <= sflg2;
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - self-checking bench for fp_mult_pipe (FP32 configuration)
module tb_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  in_tag = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] result;
   logic [3:0]  out_tag;
   logic [3:0]  flags;

   fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .out_tag   (out_tag),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stall_cnt = 0;
   int pops = 0;
   bit rdy_rand = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: exact integer product, then round by comparing the discarded remainder to one half ulp.
   function automatic int op_cls(input logic [31:0] x);
      if (x[30:23] == 8'hFF) begin
         if (x[22:0] == 0) return 2;
         return x[22] ? 3 : 4;
      end
      return (x[30:23] == 0) ? 0 : 1;
   endfunction

   function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
      int ca, cb, e, sh;
      logic s, nx;
      longint unsigned ma, mb, p, q, rem, half;
      ca = op_cls(x);
      cb = op_cls(y);
      s  = x[31] ^ y[31];
      if (ca >= 3 || cb >= 3) return {((ca == 4) || (cb == 4)) ? 4'b1000 : 4'b0000, 32'h7FC00000};
      if ((ca == 2 && cb == 0) || (ca == 0 && cb == 2)) return {4'b1000, 32'h7FC00000};
      if (ca == 2 || cb == 2) return {4'b0000, s, 8'hFF, 23'd0};
      if (ca == 0 || cb == 0) return {4'b0000, s, 31'd0};
      ma = 64'(x[22:0]) | (64'd1 << 23);
      mb = 64'(y[22:0]) | (64'd1 << 23);
      p  = ma * mb;
      e  = int'(x[30:23]) + int'(y[30:23]) - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e++;
      end
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      nx   = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {4'b0011, s, 31'd0};
      return {3'b000, nx, s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0:       r[30:23] = 8'hFF;
         1:       r[30:23] = 8'h00;
         2:       r[30:23] = 8'($urandom_range(1, 20));
         3:       r[30:23] = 8'($urandom_range(230, 254));
         4:       begin r[30:23] = 8'($urandom_range(120, 134)); r[22:0] = '1; end
         default: r[30:23] = 8'($urandom_range(100, 154));
      endcase
      return r;
   endfunction

   // Scoreboard
   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      logic [3:0]  tag;
      int          acc;
      int          stalls;
   } exp_t;

   exp_t        sb[$];
   bit          held = 1'b0;
   logic [40:0] held_val;

   always @(negedge clk) begin
      exp_t        e;
      logic [35:0] m;
      if (rst) begin
         sb.delete();
         held = 1'b0;
      end else begin
         if (held) check("hold_stable", {out_valid, result, out_tag, flags}, held_val);
         if (out_valid && out_ready) begin
            pops++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got result %h tag %h with nothing pending", result, out_tag);
            end else begin
               e = sb.pop_front();
               check("result", result, e.res);
               check("flags", flags, e.flg);
               check("tag", out_tag, e.tag);
               if (e.stalls == stall_cnt) check("latency", cyc, e.acc + 4);
            end
         end
         if (out_valid && !out_ready) begin
            stall_cnt++;
            check("in_ready_drop", in_ready, 1'b0);
            held     = 1'b1;
            held_val = {out_valid, result, out_tag, flags};
         end else begin
            held = 1'b0;
         end
         if (in_valid && in_ready) begin
            m        = model(a, b);
            e.res    = m[31:0];
            e.flg    = m[35:32];
            e.tag    = in_tag;
            e.acc    = cyc;
            e.stalls = stall_cnt;
            sb.push_back(e);
         end
      end
   end

   always @(posedge clk) begin
      if (rdy_rand) begin
         #1;
         if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
      int n;
      n = 0;
      a = x;
      b = y;
      in_tag = t;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rdy_rand = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   localparam int NDIR = 13;
   logic [31:0] dir_a [NDIR] = '{32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'h00800000, 32'hFF800000,
                                 32'h7F800001, 32'h7FC00000, 32'h3F800001, 32'h7F000001, 32'hBF800000,
                                 32'hC0000000, 32'h7F800000, 32'h40400000};
   logic [31:0] dir_b [NDIR] = '{32'h40000000, 32'h3FC00000, 32'h40000000, 32'h3F000000, 32'h00000000,
                                 32'h3F800000, 32'h3F800000, 32'h3FFFFFFE, 32'h3FFFFFFE, 32'h3F800000,
                                 32'h00400000, 32'hC0000000, 32'hC0800000};
   logic [31:0] dir_r [NDIR] = '{32'h40400000, 32'h3FC00002, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                                 32'h7FC00000, 32'h7FC00000, 32'h40000000, 32'h7F800000, 32'hBF800000,
                                 32'h80000000, 32'hFF800000, 32'hC1400000};
   logic [3:0]  dir_f [NDIR] = '{4'h0, 4'h1, 4'h5, 4'h3, 4'h8, 4'h8, 4'h0, 4'h1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int pops0;
      logic [35:0] m;

      // Pin the reference model to hand-derived results.
      for (int i = 0; i < NDIR; i++) begin
         m = model(dir_a[i], dir_b[i]);
         check($sformatf("model_vec%0d", i), m, {dir_f[i], dir_r[i]});
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_result", result, 32'h0);
      check("reset_out_tag", out_tag, 4'h0);
      check("reset_flags", flags, 4'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed vectors, back to back, consumer always ready
      for (int i = 0; i < NDIR; i++) send(dir_a[i], dir_b[i], 4'(i));
      drain();

      // Backpressure mid-stream
      pops0 = pops;
      fork
         begin
            for (int t = 0; t < 6; t++) send(rand_op(), rand_op(), 4'(t));
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("backpressure_count", pops - pops0, 6);

      // Reset with three operations in flight
      for (int t = 0; t < 3; t++) send(rand_op(), rand_op(), 4'(t + 8));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_out_valid", out_valid, 1'b0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_stale_result", seen, 0);
      @(posedge clk);
      #1;
      pops0 = pops;
      send(32'h3FC00000, 32'h40000000, 4'hA);
      drain();
      check("post_reset_op_count", pops - pops0, 1);

      // Randomised traffic with random backpressure
      rdy_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(rand_op(), rand_op(), 4'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
